// File: rtl/iq_decimator.sv
// Per-lane accumulate-and-dump decimator for an interleaved I/Q stream (8 lanes = 4 ch x I/Q).
// Define IQ_DECIMATOR_ROUND_EN to round half up before the shift instead of flooring.
module iq_decimator #(
  parameter int unsigned LOG2_DECIM = 4,
  parameter int unsigned DATA_W     = 24
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_areset,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [2:0]               s_axis_tuser,
  output logic signed [DATA_W-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [2:0]               m_axis_tuser
);

  localparam int unsigned AccW = DATA_W + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] CntLast = '1;
  localparam logic [LOG2_DECIM-1:0] CntOne  = LOG2_DECIM'(1);

  logic signed [AccW-1:0]   acc_q [8];
  logic signed [AccW-1:0]   acc_d [8];
  logic [LOG2_DECIM-1:0]    cnt_q [8];
  logic [LOG2_DECIM-1:0]    cnt_d [8];

  logic                     m_valid_q, m_valid_d;
  logic signed [DATA_W-1:0] m_data_q, m_data_d;
  logic [2:0]               m_user_q, m_user_d;

  logic                     accept;
  logic                     dump;
  logic signed [AccW-1:0]   samp_ext;
  logic signed [AccW-1:0]   acc_sum;
  logic signed [DATA_W-1:0] dump_val;

  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  // clear restarts the window, so the addressed sample can never complete one
  assign dump          = accept && !clear && (cnt_q[s_axis_tuser] == CntLast);

  assign samp_ext = {{LOG2_DECIM{s_axis_tdata[DATA_W-1]}}, s_axis_tdata};
  assign acc_sum  = acc_q[s_axis_tuser] + samp_ext;

`ifdef IQ_DECIMATOR_ROUND_EN
  localparam logic signed [AccW-1:0] RndOfs = AccW'(2 ** (LOG2_DECIM - 1));
  logic signed [AccW-1:0] rnd_sum;
  assign rnd_sum  = acc_sum + RndOfs;
  assign dump_val = rnd_sum[AccW-1:LOG2_DECIM];
`else
  // Upper DATA_W bits of the sum are the floor-shifted mean
  assign dump_val = acc_sum[AccW-1:LOG2_DECIM];
`endif

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      for (int i = 0; i < 8; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
    end
    if (accept) begin
      if (clear) begin
        acc_d[s_axis_tuser] = samp_ext;
        cnt_d[s_axis_tuser] = CntOne;
      end else if (dump) begin
        acc_d[s_axis_tuser] = '0;
        cnt_d[s_axis_tuser] = '0;
      end else begin
        acc_d[s_axis_tuser] = acc_sum;
        cnt_d[s_axis_tuser] = cnt_q[s_axis_tuser] + CntOne;
      end
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end
    if (dump) begin
      m_valid_d = 1'b1;
      m_data_d  = dump_val;
      m_user_d  = s_axis_tuser;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      for (int i = 0; i < 8; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_user_q  <= m_user_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_iq_decimator.sv
// Directed bench for iq_decimator with LOG2_DECIM=2, DATA_W=24.
// Expected means follow IQ_DECIMATOR_ROUND_EN when it is defined for the build.
module tb_iq_decimator;

`ifdef IQ_DECIMATOR_ROUND_EN
  localparam int Rnd = 2;
`else
  localparam int Rnd = 0;
`endif

  logic               clk = 1'b0;
  logic               areset;
  logic               clear;
  logic signed [23:0] s_tdata;
  logic               s_tvalid;
  logic               s_tready;
  logic [2:0]         s_tuser;
  logic signed [23:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic [2:0]         m_tuser;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iq_decimator #(
    .LOG2_DECIM (2),
    .DATA_W     (24)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (areset),
    .clear         (clear),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser)
  );

  typedef struct {
    int user;
    int data;
    bit ev;
    int ed;
  } vec_t;

  vec_t rr [32];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input bit v, input int d, input int u);
    chk({name, "_valid"}, int'(m_tvalid), int'(v));
    if (v) begin
      chk({name, "_data"}, int'(m_tdata), d);
      chk({name, "_user"}, int'(m_tuser), u);
    end
  endtask

  // One clock: drive at negedge, sample 1 ns after the rising edge
  task automatic step(input bit rst, input bit v, input int u, input int d, input bit clr,
                      input bit rdy);
    logic [2:0]  u3;
    logic [23:0] d24;
    u3  = u[2:0];
    d24 = d[23:0];
    @(negedge clk);
    areset   = rst;
    s_tvalid = v;
    s_tuser  = u3;
    s_tdata  = d24;
    clear    = clr;
    m_tready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input string name, input int lane, input int d0, input int d1,
                       input int d2, input int d3, input int exp);
    step(0, 1, lane, d0, 0, 1); expect_out({name, "_s0"}, 0, 0, 0);
    step(0, 1, lane, d1, 0, 1); expect_out({name, "_s1"}, 0, 0, 0);
    step(0, 1, lane, d2, 0, 1); expect_out({name, "_s2"}, 0, 0, 0);
    step(0, 1, lane, d3, 0, 1); expect_out({name, "_dump"}, 1, exp, lane);
    step(0, 0, 0, 0, 0, 1);     expect_out({name, "_drop"}, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 8; l++) begin
        rr[k*8+l].user = l;
        rr[k*8+l].data = l * 100 + k;
        rr[k*8+l].ev   = (k == 3);
        rr[k*8+l].ed   = (l * 400 + 6 + Rnd) >>> 2;
      end
    end

    areset   = 1'b1;
    clear    = 1'b0;
    s_tvalid = 1'b0;
    s_tuser  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(m_tvalid), 0);
    chk("rst_data", int'(m_tdata), 0);
    chk("rst_user", int'(m_tuser), 0);
    chk("rst_sready", int'(s_tready), 1);

    // Basic mean on lane 0: 10/4
    feed4("lane0", 0, 1, 2, 3, 4, (10 + Rnd) >>> 2);

    // Round-robin interleave of all 8 lanes
    for (int i = 0; i < 32; i++) begin
      step(0, 1, rr[i].user, rr[i].data, 0, 1);
      expect_out($sformatf("rr%0d", i), rr[i].ev, rr[i].ed, rr[i].user);
    end
    step(0, 0, 0, 0, 0, 1);
    expect_out("rr_drop", 0, 0, 0);

    feed4("neg5", 5, -1, -2, -2, -2, (-7 + Rnd) >>> 2);
    feed4("fs_pos", 6, 8388607, 8388607, 8388607, 8388607, 8388607);
    feed4("fs_neg", 7, -8388608, -8388608, -8388608, -8388608, -8388608);

    // Backpressure: lane 2 preloaded, lane 1 dumps into a stalled sink
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2, 20, 0, 1); expect_out("bp_pre2", 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 10, 0, 1); expect_out("bp_pre1", 0, 0, 0);
    end
    step(0, 1, 1, 10, 0, 0);
    expect_out("bp_dump1", 1, 10, 1);
    chk("bp_sready_low", int'(s_tready), 0);
    step(0, 1, 2, 999, 0, 0);
    expect_out("bp_hold", 1, 10, 1);
    chk("bp_sready_hold", int'(s_tready), 0);
    step(0, 1, 2, 20, 0, 1);
    expect_out("bp_b2b", 1, 20, 2);
    step(0, 0, 0, 0, 0, 1);
    expect_out("bp_drop", 0, 0, 0);

    // Clear arrives with what would have been the dumping sample
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 3, 1, 0, 1); expect_out("clr_pre", 0, 0, 0);
    end
    step(0, 1, 3, 8, 1, 1);
    expect_out("clr_nodump", 0, 0, 0);
    step(0, 1, 3, 8, 0, 1); expect_out("clr_s1", 0, 0, 0);
    step(0, 1, 3, 8, 0, 1); expect_out("clr_s2", 0, 0, 0);
    step(0, 1, 3, 8, 0, 1); expect_out("clr_dump", 1, (32 + Rnd) >>> 2, 3);
    step(0, 0, 0, 0, 0, 1); expect_out("clr_drop", 0, 0, 0);

    // Reset mid-window on lane 4
    step(0, 1, 4, 100, 0, 1); expect_out("rmw_pre0", 0, 0, 0);
    step(0, 1, 4, 100, 0, 1); expect_out("rmw_pre1", 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("rmw_rst_valid", int'(m_tvalid), 0);
    chk("rmw_rst_data", int'(m_tdata), 0);
    feed4("rmw", 4, 4, 4, 4, 4, (16 + Rnd) >>> 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_decimator.md
Name: iq_decimator

Overview:
- Sits directly downstream of the I/Q demodulator.
- Consumes its interleaved I/Q sample stream, where tuser = {channel[1:0], q_flag}.
- Low-pass filters and decimates each of the 8 lanes (4 channels x I/Q) with an independent accumulate-and-dump integrator.
- Emits one averaged sample per lane every 2**LOG2_DECIM input samples of that lane, tagged with the same tuser.

Parameters:
- LOG2_DECIM, 4: decimation factor exponent; DECIM = 2**LOG2_DECIM; legal range 1..8.
- DATA_W, 24: input and output sample width, signed.

Ports:
- s_axis_aclk  in  1  single clock for the whole block.
- s_axis_areset  in  1  reset: synchronous, active-high.
- clear  in  1  synchronous flush of all partial windows (pulse at start of each ping).
- s_axis_tdata  in  DATA_W  signed demodulated sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  3  lane index = {channel, q_flag}.
- m_axis_tdata  out  DATA_W  signed decimated sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tuser  out  3  lane index of m_axis_tdata.

Behaviour:
- Lane state, 8 entries indexed by tuser:
  - acc[lane], signed DATA_W+LOG2_DECIM bits.
  - cnt[lane], LOG2_DECIM bits.
- Reset: all acc = 0, all cnt = 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0. A reset mid-window discards all partial sums.
- Accept: s_axis_tvalid & s_axis_tready.
- s_axis_tready = !m_axis_tvalid | m_axis_tready (single-entry output register; full throughput when the sink is always ready).
- On accept with cnt[lane] != DECIM-1:
  - acc[lane] <= acc[lane] + sext(tdata).
  - cnt[lane] <= cnt[lane] + 1.
- On accept with cnt[lane] == DECIM-1 (dump):
  - sum = acc[lane] + sext(tdata).
  - m_axis_tdata <= sum >>> LOG2_DECIM (arithmetic shift, floor).
  - m_axis_tuser <= lane.
  - m_axis_tvalid <= 1.
  - acc[lane] <= 0, cnt[lane] <= 0.
- Width: the result always fits DATA_W (it is a mean of DATA_W values); no saturation logic required.
- Latency: one cycle from accept of the dumping sample to m_axis_tvalid high.
- Output hold: m_axis_tvalid, tdata and tuser stay stable until m_axis_tready. m_axis_tvalid drops the cycle after a handshake unless a new dump loads in the same cycle.
- Simultaneous handshake and dump: the output register reloads and m_axis_tvalid stays 1. No bubble, no loss.
- Lanes are fully independent: arbitrary interleave order and uneven lane rates are legal.
- Only the lane addressed by s_axis_tuser changes state on an accept.
- clear high:
  - All acc = 0 and all cnt = 0 on that edge.
  - If an accept occurs on the same edge, that sample becomes the first of a new window: acc[lane] = sext(tdata), cnt[lane] = 1.
  - clear never produces a dump and never affects the output register or a pending m_axis_tvalid.
- Reset overrides clear and accept.
- No combinational path from s_axis_tdata to m_axis_*.
- The only combinational input-to-output path is m_axis_tready -> s_axis_tready.

Optional Feature:
- Macro: IQ_DECIMATOR_ROUND_EN.
- Defined: add 2**(LOG2_DECIM-1) to sum before the arithmetic shift (round half up). The result still fits DATA_W: max input gives 8388607, min input gives -8388608.
- Undefined: pure floor shift as above; no adder present.

Test Plan:
- Test parameters: LOG2_DECIM=2, sink always ready. Lane 0 samples 1, 2, 3, 4 -> single output tdata=2 (floor 10/4), tuser=0, one cycle after the 4th accept. With IQ_DECIMATOR_ROUND_EN: tdata=3.
- Interleave lanes 0..7 round-robin with values lane*100 + k, k=0..3 -> 8 outputs in lane order 0..7, tdata = lane*100 + 1 (floor of +1.5), each tuser correct.
- Negative values -1, -2, -2, -2 on lane 5 -> tdata=-2 (floor -7/4).
- Full-scale inputs: 4x 8388607 -> 8388607; 4x -8388608 -> -8388608. Check with and without the macro.
- Hold m_axis_tready=0 while lane 1 dumps -> s_axis_tready=0 the next cycle, output stable. Release tready in the same cycle as a lane 2 dump is presented -> back-to-back outputs, no loss.
- Lane 3: accept 3 samples, pulse clear together with the 4th sample (value 8), then 3 more samples of 8 -> first lane 3 output = 8.
- Reset mid-window on lane 4 (2 samples in), then 4 samples of 4 -> output tdata=4.
